// File: rtl/dmux_stream_router.sv
// Registered N-way stream demultiplexer with unicast/broadcast routing,
// one-entry holding register per output channel and an accepted-transfer counter.
module dmux_stream_router #(
    parameter int WIDTH    = 16,
    parameter int SEL_BITS = 2,
    localparam int WAYS    = 2 ** SEL_BITS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    input  logic [SEL_BITS-1:0]     in_sel,
    input  logic                    in_bcast,
    output logic [WAYS-1:0]         out_valid,
    input  logic [WAYS-1:0]         out_ready,
    output logic [WAYS*WIDTH-1:0]   out_data,
    output logic [15:0]             xfer_count
);

    logic [WAYS-1:0] free;
    logic [WAYS-1:0] load;
    logic            accept;

    // A channel is free when empty or draining this cycle; broadcast needs every channel free.
    always_comb begin
        free     = ~out_valid | out_ready;
        in_ready = in_bcast ? (&free) : free[in_sel];
        accept   = in_valid && in_ready;
        load     = '0;
        if (accept) begin
            if (in_bcast) begin
                load = '1;
            end else begin
                load[in_sel] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= '0;
            out_data   <= '0;
            xfer_count <= '0;
        end else begin
            for (int k = 0; k < WAYS; k++) begin
                if (load[k]) begin
                    out_valid[k]                 <= 1'b1;
                    out_data[k*WIDTH +: WIDTH]   <= in_data;
                end else if (out_ready[k]) begin
                    out_valid[k]                 <= 1'b0;
                end
            end
            if (accept) begin
                xfer_count <= xfer_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_dmux_stream_router.sv
// Self-checking bench for dmux_stream_router: per-channel scoreboard queues
// filled on modelled accepts and drained when the modelled consumer takes a word.
module tb_dmux_stream_router;

    localparam int WIDTH    = 16;
    localparam int SEL_BITS = 2;
    localparam int WAYS     = 4;

    logic                  clk;
    logic                  reset;
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      in_data;
    logic [SEL_BITS-1:0]   in_sel;
    logic                  in_bcast;
    logic [WAYS-1:0]       out_valid;
    logic [WAYS-1:0]       out_ready;
    logic [WAYS*WIDTH-1:0] out_data;
    logic [15:0]           xfer_count;

    int checks;
    int errors;

    logic [WIDTH-1:0] exp_q [WAYS][$];
    logic [WIDTH-1:0] exp_lane [WAYS];
    logic [15:0]      exp_count;

    dmux_stream_router #(.WIDTH(WIDTH), .SEL_BITS(SEL_BITS)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_bcast   (in_bcast),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .xfer_count (xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Drives one cycle, advances the reference model and checks the registered outputs after the edge.
    task automatic applyStimulus(input logic rst, input logic v, input logic [WIDTH-1:0] d,
                                 input logic [SEL_BITS-1:0] s, input logic b, input logic [WAYS-1:0] r);
        logic            exp_ready;
        logic            acc;
        logic [WAYS-1:0] fr;
        logic [WAYS-1:0] ev;
        logic [WIDTH-1:0] w;
        reset     = rst;
        in_valid  = v;
        in_data   = d;
        in_sel    = s;
        in_bcast  = b;
        out_ready = r;
        @(negedge clk);
        for (int k = 0; k < WAYS; k++) fr[k] = (exp_q[k].size() == 0) || r[k];
        exp_ready = b ? (&fr) : fr[s];
        if (!rst) checkOutput("in_ready", {63'd0, in_ready}, {63'd0, exp_ready});
        acc = !rst && v && exp_ready;
        if (rst) begin
            for (int k = 0; k < WAYS; k++) begin
                exp_q[k].delete();
                exp_lane[k] = '0;
            end
            exp_count = '0;
        end else begin
            for (int k = 0; k < WAYS; k++) begin
                if (r[k] && exp_q[k].size() > 0) begin
                    w = exp_q[k].pop_front();
                    checkOutput($sformatf("drain_data%0d", k), {48'd0, out_data[k*WIDTH +: WIDTH]}, {48'd0, w});
                end
                if (acc && (b || s == k[SEL_BITS-1:0])) begin
                    exp_q[k].push_back(d);
                    exp_lane[k] = d;
                end
            end
            if (acc) exp_count = exp_count + 16'd1;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < WAYS; k++) ev[k] = (exp_q[k].size() != 0);
        checkOutput("out_valid", {60'd0, out_valid}, {60'd0, ev});
        for (int k = 0; k < WAYS; k++)
            checkOutput($sformatf("lane%0d", k), {48'd0, out_data[k*WIDTH +: WIDTH]}, {48'd0, exp_lane[k]});
        checkOutput("xfer_count", {48'd0, xfer_count}, {48'd0, exp_count});
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_count = '0;
        for (int k = 0; k < WAYS; k++) exp_lane[k] = '0;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = '0; in_bcast = 1'b0; out_ready = '0;

        applyStimulus(1, 0, 16'h0, 0, 0, 4'h0);
        applyStimulus(1, 0, 16'h0, 0, 0, 4'h0);
        checkOutput("reset_valid", {60'd0, out_valid}, 64'h0);
        checkOutput("reset_data", out_data, 64'h0);
        checkOutput("reset_count", {48'd0, xfer_count}, 64'h0);
        for (int k = 0; k < WAYS; k++) applyStimulus(0, 0, 16'h0, k[1:0], 0, 4'h0);
        applyStimulus(0, 0, 16'h0, 0, 1, 4'h0);

        // Unicast sweep, all consumers ready.
        for (int k = 0; k < WAYS; k++) begin
            applyStimulus(0, 1, 16'hA000 + 16'(k), k[1:0], 0, 4'hF);
            checkOutput("sweep_onehot", {60'd0, out_valid}, 64'd1 << k);
        end
        checkOutput("sweep_count", {48'd0, xfer_count}, 64'd4);
        applyStimulus(0, 0, 16'h0, 0, 0, 4'hF);

        // Backpressure on channel 2, then same-cycle drain and refill.
        applyStimulus(0, 1, 16'h1234, 2, 0, 4'b1011);
        applyStimulus(0, 1, 16'h5678, 2, 0, 4'b1011);
        checkOutput("bp_hold", {48'd0, out_data[2*WIDTH +: WIDTH]}, 64'h1234);
        applyStimulus(0, 1, 16'h5678, 2, 0, 4'b1111);
        checkOutput("bp_refill", {48'd0, out_data[2*WIDTH +: WIDTH]}, 64'h5678);
        applyStimulus(0, 0, 16'h0, 0, 0, 4'hF);

        // Broadcast blocked by a stalled channel 1.
        applyStimulus(0, 1, 16'h0101, 1, 0, 4'b1101);
        applyStimulus(0, 1, 16'hBEEF, 3, 1, 4'b1101);
        applyStimulus(0, 1, 16'hBEEF, 3, 1, 4'b1111);
        applyStimulus(0, 0, 16'h0, 0, 0, 4'h0);
        checkOutput("bcast_valid", {60'd0, out_valid}, 64'hF);
        checkOutput("bcast_data", out_data, 64'hBEEF_BEEF_BEEF_BEEF);
        applyStimulus(0, 0, 16'h0, 0, 0, 4'hF);

        // Reset mid-operation with a concurrent accept.
        applyStimulus(0, 1, 16'h1111, 0, 0, 4'h0);
        applyStimulus(0, 1, 16'h2222, 1, 0, 4'h0);
        applyStimulus(0, 1, 16'h3333, 3, 0, 4'h0);
        checkOutput("mid_valid", {60'd0, out_valid}, 64'hB);
        applyStimulus(1, 1, 16'h7777, 2, 0, 4'h0);
        checkOutput("mid_reset_valid", {60'd0, out_valid}, 64'h0);
        checkOutput("mid_reset_data", out_data, 64'h0);
        checkOutput("mid_reset_count", {48'd0, xfer_count}, 64'h0);

        // Counter wrap: 65536 accepts return to zero, one more gives one.
        for (int i = 0; i < 65536; i++)
            applyStimulus(0, 1, 16'(i), 2'(i), 0, 4'hF);
        checkOutput("wrap_zero", {48'd0, xfer_count}, 64'h0);
        applyStimulus(0, 1, 16'hCAFE, 1, 0, 4'hF);
        checkOutput("wrap_one", {48'd0, xfer_count}, 64'h1);
        applyStimulus(0, 0, 16'h0, 0, 0, 4'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmux_stream_router.md
Name: dmux_stream_router

Overview:
- Registered, parametrised N-way demultiplexer. Routes one input data stream to one of WAYS output channels, or to all of them (broadcast).
- Uses a valid/ready handshake on every port.
- Sequential successor to the combinational 1-bit 4-way demux. Used wherever a producer must steer words to multiple consumers that stall independently.
- Each output channel has a one-entry holding register. A 16-bit counter tracks accepted transfers.

Parameters:
- WIDTH, 16, data word width in bits (>=1).
- SEL_BITS, 2, selector width. WAYS = 2**SEL_BITS output channels (SEL_BITS >= 1).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  router can accept this cycle (combinational).
- in_data  input  WIDTH  input word.
- in_sel  input  SEL_BITS  target channel index (ignored when in_bcast=1).
- in_bcast  input  1  1 = deliver word to all channels.
- out_valid  output  WAYS  bit k: channel k holding register full.
- out_ready  input  WAYS  bit k: consumer k takes word this cycle.
- out_data  output  WAYS*WIDTH  channel k word at bits [k*WIDTH +: WIDTH].
- xfer_count  output  16  number of accepted input transfers, wraps.

Behaviour:
- Reset, when reset=1 at a rising edge:
  - out_valid=0, out_data=0 on all lanes, xfer_count=0.
  - Reset overrides any concurrent accept or drain.
  - in_ready may be evaluated but no transfer is counted or stored.
- Channel k is free when !out_valid[k] || out_ready[k]. Same-cycle drain-and-refill is allowed, so full throughput is 1 word/cycle per channel.
- in_ready:
  - in_bcast=0: in_ready = free[in_sel].
  - in_bcast=1: in_ready = AND of free[k] over all k. Broadcast is all-or-nothing; there is never a partial delivery.
  - in_ready depends only on current state, in_sel, in_bcast and out_ready. It never depends on in_valid.
- Accept = in_valid && in_ready. On accept:
  - Target register(s) load in_data and set out_valid at the next edge.
  - Latency: word visible on out_data/out_valid exactly 1 cycle after accept.
  - xfer_count increments by 1 per accept, including broadcast, modulo 2**16 (0xFFFF -> 0x0000).
- Per-channel update, priority order:
  1. reset;
  2. load (channel targeted by an accept) -> out_valid[k]=1, data = in_data;
  3. drain (out_valid[k] && out_ready[k], no load) -> out_valid[k]=0, data held;
  4. otherwise hold.
- out_data lanes of non-valid channels hold their last loaded value (0 after reset). Consumers must qualify data with out_valid.
- Producer rule (checked by bench): once in_valid=1 with in_ready=0, the producer holds in_data/in_sel/in_bcast stable until accept. The router must not depend on this for correctness.
- out_ready on a channel with out_valid=0 has no effect.
- Channels are independent. A stalled channel k blocks only unicasts to k and all broadcasts.
- No combinational path from in_valid/in_data to any output other than through registers.

Test Plan:
- Reset then idle: reset=1 for 2 cycles -> out_valid=0000, all out_data lanes 0x0000, xfer_count=0, in_ready=1 for every sel.
- Unicast sweep with all out_ready=1:
  - Stimulus: in_data=0xA000+k, sel=k, k=0..3 on consecutive cycles.
  - Required: each cycle in_ready=1; one cycle later out_valid=one-hot(k) and lane k=0xA000+k; xfer_count=4 at end.
- Backpressure on channel 2:
  - Stimulus: out_ready[2]=0, send 0x1234 to sel=2, then 0x5678 to sel=2.
  - Required: first accepted; second sees in_ready=0 while lane 2 holds 0x1234. Raise out_ready[2] -> same-cycle drain/refill; lane 2=0x5678 next cycle; no word lost or duplicated.
- Broadcast blocking:
  - Stimulus: channel 1 full with out_ready[1]=0, issue in_bcast=1 with 0xBEEF.
  - Required: in_ready=0, no lane changes, xfer_count unchanged. Release out_ready[1] -> all four lanes=0xBEEF, out_valid=1111, xfer_count +1.
- Counter wrap: 65536 unicast accepts from reset -> xfer_count returns to 0x0000; 65537th -> 0x0001.
- Reset mid-operation: out_valid=1011 with a concurrent accept to sel=2 and reset=1 -> next cycle out_valid=0000, lanes 0, xfer_count=0.
